// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port register file with write bypass and busy-bit scoreboard
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    output logic                     issue_ready,
    output logic                     stall,
    output logic [DEPTH-1:0]         busy_vec
);
    logic [XLEN-1:0]  regs_q [DEPTH];
    logic [XLEN-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             wr_hit, iss_zero, issue_take;

    // Write qualification, issue acceptance and hazard stall; writes are ignored while in reset
    always_comb begin
        wr_hit      = we && !rst && !(ZERO_REG != 0 && waddr == '0);
        iss_zero    = ZERO_REG != 0 && issue_rd == '0;
        issue_ready = !busy_q[issue_rd] || (wr_hit && waddr == issue_rd) || iss_zero;
        issue_take  = issue_valid && issue_ready && !iss_zero;
        stall       = |(rd_en & rd_busy) || (issue_valid && !issue_ready);
        busy_vec    = busy_q;
    end

    // Next state: a write stores data and retires the producer, an accepted issue then claims ownership
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_hit) begin
            regs_d[waddr] = wdata;
            busy_d[waddr] = 1'b0;
        end
        if (issue_take) busy_d[issue_rd] = 1'b1;
    end

    // Storage and busy bits, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] a;
        logic          z, byp;
        assign a   = rd_addr[p*AW +: AW];
        assign z   = ZERO_REG != 0 && a == '0;
        assign byp = BYPASS != 0 && wr_hit && waddr == a;
        assign rd_data[p*XLEN +: XLEN] = z ? '0 : byp ? wdata : regs_q[a];
        assign rd_busy[p] = busy_q[a] && !byp && !z;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: randomized and directed checks of reg_file_sb against a behavioural model
module tb_reg_file_sb;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rd_en;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data;
    logic [3:0]   rd_busy;
    logic         we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         issue_ready, stall;
    logic [31:0]  busy_vec;
    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;
    logic         issue_ready_b, stall_b;
    logic [31:0]  busy_vec_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mreg [32];
    bit          mbusy [32];

    always #5 clk = ~clk;

    reg_file_sb #(.NUM_RD(4), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_ready(issue_ready), .stall(stall), .busy_vec(busy_vec)
    );

    reg_file_sb #(.NUM_RD(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_en(rd_en[1:0]), .rd_addr(rd_addr[9:0]), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_ready(issue_ready_b), .stall(stall_b), .busy_vec(busy_vec_b)
    );

    function automatic logic [31:0] e_data(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we && !rst && waddr == a) return wdata;
        return mreg[a];
    endfunction

    function automatic logic e_rbusy(input logic [4:0] a, input bit byp);
        return a != 0 && mbusy[a] && !(byp && we && !rst && waddr == a);
    endfunction

    function automatic logic e_ready();
        return issue_rd == 0 || !mbusy[issue_rd] || (we && !rst && waddr == issue_rd);
    endfunction

    function automatic logic e_stall(input int nports, input bit byp);
        logic s = issue_valid && !e_ready();
        for (int p = 0; p < nports; p++) s |= rd_en[p] && e_rbusy(rd_addr[p*5 +: 5], byp);
        return s;
    endfunction

    function automatic logic [31:0] e_busyvec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mreg[i] = 0;
            mbusy[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic r;
        if (rst) return;
        r = e_ready();
        if (we && waddr != 0) begin
            mreg[waddr] = wdata;
            mbusy[waddr] = 0;
        end
        if (issue_valid && r && issue_rd != 0) mbusy[issue_rd] = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; we = 0; waddr = '0; wdata = '0; issue_valid = 0; issue_rd = '0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); model_reset();
        @(negedge clk); #1;
        n_cmp++; if (busy_vec !== 32'h0) begin n_bad++; $display("FAIL reset_busy got %h want 0", busy_vec); end
        n_cmp++; if (issue_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL reset_ready_stall got %b%b want 10", issue_ready, stall); end
        rst = 0;
        @(negedge clk);
        we = 1; waddr = 5; wdata = 32'hDEADBEEF; issue_valid = 1; issue_rd = 6;
        tick();
        idle(); rd_addr[4:0] = 5; #1;
        n_cmp++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL reset_pre_r5 got %h want deadbeef", rd_data[31:0]); end
        n_cmp++; if (busy_vec !== 32'h40) begin n_bad++; $display("FAIL reset_pre_busy got %h want 40", busy_vec); end
        #1; rst = 1; we = 1; waddr = 5; wdata = 32'h55; model_reset(); #1;
        n_cmp++; if (rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL reset_mid_r5 got %h want 0", rd_data[31:0]); end
        n_cmp++; if (busy_vec !== 32'h0 || stall !== 1'b0 || issue_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_state got busy %h stall %b ready %b want 0 0 1", busy_vec, stall, issue_ready); end
        tick();
        rst = 0; idle();
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
        we = 1; waddr = 0; wdata = 32'hFFFFFFFF; rd_addr = '0; rd_en = 4'hF; issue_valid = 1; issue_rd = 0; #1;
        for (int p = 0; p < 4; p++) begin
            n_cmp++; if (rd_data[p*32 +: 32] !== 32'h0) begin n_bad++; $display("FAIL zero_rd%0d got %h want 0", p, rd_data[p*32 +: 32]); end
        end
        n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL zero_issue_ready got %b want 1", issue_ready); end
        tick();
        idle(); #1;
        n_cmp++; if (busy_vec[0] !== 1'b0 || rd_data[31:0] !== 32'h0) begin n_bad++; $display("FAIL zero_after got busy0 %b data %h want 0 0", busy_vec[0], rd_data[31:0]); end
    endtask

    task automatic test_bypass();
        we = 1; waddr = 7; wdata = 32'h12345678; rd_addr[4:0] = 7; #1;
        n_cmp++; if (rd_data[31:0] !== 32'h12345678) begin n_bad++; $display("FAIL bypass_same got %h want 12345678", rd_data[31:0]); end
        n_cmp++; if (rd_data_b[31:0] !== 32'h0) begin n_bad++; $display("FAIL nobypass_same got %h want 0", rd_data_b[31:0]); end
        tick();
        we = 0; #1;
        n_cmp++; if (rd_data_b[31:0] !== 32'h12345678) begin n_bad++; $display("FAIL nobypass_next got %h want 12345678", rd_data_b[31:0]); end
    endtask

    task automatic test_raw();
        idle(); issue_valid = 1; issue_rd = 3;
        tick();
        idle(); rd_en[0] = 1; rd_addr[4:0] = 3;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (rd_busy[0] !== 1'b1 || stall !== 1'b1) begin n_bad++; $display("FAIL raw_wait%0d got busy %b stall %b want 1 1", c, rd_busy[0], stall); end
            tick();
        end
        we = 1; waddr = 3; wdata = 32'hA5A5_0003; #1;
        n_cmp++; if (rd_busy[0] !== 1'b0 || stall !== 1'b0 || rd_data[31:0] !== 32'hA5A5_0003) begin n_bad++; $display("FAIL raw_write got busy %b stall %b data %h want 0 0 a5a50003", rd_busy[0], stall, rd_data[31:0]); end
        n_cmp++; if (rd_busy_b[0] !== 1'b1 || stall_b !== 1'b1) begin n_bad++; $display("FAIL raw_write_nb got busy %b stall %b want 1 1", rd_busy_b[0], stall_b); end
        tick();
        we = 0; #1;
        n_cmp++; if (busy_vec[3] !== 1'b0 || rd_busy_b[0] !== 1'b0) begin n_bad++; $display("FAIL raw_after got %b %b want 0 0", busy_vec[3], rd_busy_b[0]); end
        idle();
    endtask

    task automatic test_waw();
        issue_valid = 1; issue_rd = 9;
        tick();
        #1;
        n_cmp++; if (issue_ready !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL waw_block got ready %b stall %b want 0 1", issue_ready, stall); end
        tick();
        #1;
        n_cmp++; if (busy_vec !== e_busyvec() || busy_vec[9] !== 1'b1) begin n_bad++; $display("FAIL waw_hold got %h want %h", busy_vec, e_busyvec()); end
        we = 1; waddr = 9; wdata = 32'h99; #1;
        n_cmp++; if (issue_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL collide_ready got ready %b stall %b want 1 0", issue_ready, stall); end
        tick();
        idle(); #1;
        n_cmp++; if (busy_vec[9] !== 1'b1) begin n_bad++; $display("FAIL collide_busy got %b want 1", busy_vec[9]); end
        we = 1; waddr = 9; wdata = 32'h100;
        tick();
        idle(); #1;
        n_cmp++; if (busy_vec[9] !== 1'b0) begin n_bad++; $display("FAIL waw_clear got %b want 0", busy_vec[9]); end
    endtask

    task automatic test_multi_port();
        for (int i = 1; i <= 4; i++) begin
            we = 1; waddr = 5'(i); wdata = 32'(i);
            tick();
        end
        idle();
        for (int p = 0; p < 4; p++) rd_addr[p*5 +: 5] = 5'(p + 1);
        #1;
        for (int p = 0; p < 4; p++) begin
            n_cmp++; if (rd_data[p*32 +: 32] !== 32'(p + 1)) begin n_bad++; $display("FAIL multi_rd%0d got %h want %h", p, rd_data[p*32 +: 32], p + 1); end
        end
        rd_addr = {4{5'd2}}; #1;
        n_cmp++; if (rd_data !== {4{32'd2}}) begin n_bad++; $display("FAIL multi_same got %h want all 2", rd_data); end
        idle();
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst = ($urandom_range(0, 499) == 0);
            if (rst) model_reset();
            rd_en = 4'($urandom);
            for (int p = 0; p < 4; p++) rd_addr[p*5 +: 5] = 5'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7));
            we = $urandom_range(0, 1);
            waddr = 5'($urandom_range(0, 7));
            wdata = $urandom;
            issue_valid = $urandom_range(0, 1);
            issue_rd = 5'($urandom_range(0, 7));
            #1;
            for (int p = 0; p < 4; p++) begin
                a = rd_addr[p*5 +: 5];
                n_cmp++; if (rd_data[p*32 +: 32] !== e_data(a, 1)) begin n_bad++; $display("FAIL rnd_rd%0d cyc %0d got %h want %h", p, cyc, rd_data[p*32 +: 32], e_data(a, 1)); end
                n_cmp++; if (rd_busy[p] !== e_rbusy(a, 1)) begin n_bad++; $display("FAIL rnd_busy%0d cyc %0d got %b want %b", p, cyc, rd_busy[p], e_rbusy(a, 1)); end
                if (p < 2) begin
                    n_cmp++; if (rd_data_b[p*32 +: 32] !== e_data(a, 0) || rd_busy_b[p] !== e_rbusy(a, 0)) begin n_bad++; $display("FAIL rnd_nb%0d cyc %0d got %h/%b want %h/%b", p, cyc, rd_data_b[p*32 +: 32], rd_busy_b[p], e_data(a, 0), e_rbusy(a, 0)); end
                end
            end
            n_cmp++; if (issue_ready !== e_ready() || issue_ready_b !== e_ready()) begin n_bad++; $display("FAIL rnd_ready cyc %0d got %b/%b want %b", cyc, issue_ready, issue_ready_b, e_ready()); end
            n_cmp++; if (stall !== e_stall(4, 1) || stall_b !== e_stall(2, 0)) begin n_bad++; $display("FAIL rnd_stall cyc %0d got %b/%b want %b/%b", cyc, stall, stall_b, e_stall(4, 1), e_stall(2, 0)); end
            n_cmp++; if (busy_vec !== e_busyvec() || busy_vec_b !== e_busyvec()) begin n_bad++; $display("FAIL rnd_busyvec cyc %0d got %h/%h want %h", cyc, busy_vec, busy_vec_b, e_busyvec()); end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_bypass();
        test_raw();
        test_waw();
        test_multi_port();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
